// File: rtl/vga_maze_top_if.sv
// vga_maze_top_if: board-facing buttons, VGA pins and seven-segment pins of the maze game.
// master is the design side, slave is the board/testbench side.
interface vga_maze_top_if;
   logic       BtnU, BtnD, BtnL, BtnR;
   logic       hSync, vSync;
   logic [3:0] vgaR, vgaG, vgaB;
   logic       An0, An1, An2, An3, An4, An5, An6, An7;
   logic       Ca, Cb, Cc, Cd, Ce, Cf, Cg, Dp;
   modport master (
      input  BtnU, BtnD, BtnL, BtnR,
      output hSync, vSync, vgaR, vgaG, vgaB,
      output An0, An1, An2, An3, An4, An5, An6, An7,
      output Ca, Cb, Cc, Cd, Ce, Cf, Cg, Dp
   );
   modport slave (
      output BtnU, BtnD, BtnL, BtnR,
      input  hSync, vSync, vgaR, vgaG, vgaB,
      input  An0, An1, An2, An3, An4, An5, An6, An7,
      input  Ca, Cb, Cc, Cd, Ce, Cf, Cg, Dp
   );
endinterface

// File: rtl/vga_maze_top.sv
// vga_maze_top: 640x480 VGA maze renderer with debounced player movement and a hex move counter.
// Player starts at cell (1,1); reaching cell (28,18) freezes movement until reset.
module vga_maze_top #(
   parameter int CLK_DIV         = 4,
   parameter int DEBOUNCE_CYCLES = 1048576,
   parameter int CELL_PX         = 16
) (
   input  logic           ClkPort,
   input  logic           BtnC,
   vga_maze_top_if.master bus,
   output logic [9:0]     x_coord,
   output logic [9:0]     y_coord,
   output logic           map_data_out_debug
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   // Column 1 and row 18 are fully open, giving a guaranteed path from start to goal.
   function automatic logic [29:0] map_row(input logic [9:0] r);
      return (r == 10'd0 || r == 10'd19) ? 30'h3FFF_FFFF :
             (r > 10'd19)                ? 30'h0000_0000 :
             (r == 10'd18)               ? 30'h2000_0001 :
             r[0]                        ? 30'h2AAA_AAA9 : 30'h3FFF_FFF9;
   endfunction

   function automatic logic [6:0] seg_hex(input logic [3:0] n);
      case (n)
         4'h0: seg_hex = 7'b1000000;
         4'h1: seg_hex = 7'b1111001;
         4'h2: seg_hex = 7'b0100100;
         4'h3: seg_hex = 7'b0110000;
         4'h4: seg_hex = 7'b0011001;
         4'h5: seg_hex = 7'b0010010;
         4'h6: seg_hex = 7'b0000010;
         4'h7: seg_hex = 7'b1111000;
         4'h8: seg_hex = 7'b0000000;
         4'h9: seg_hex = 7'b0010000;
         4'hA: seg_hex = 7'b0001000;
         4'hB: seg_hex = 7'b0000011;
         4'hC: seg_hex = 7'b1000110;
         4'hD: seg_hex = 7'b0100001;
         4'hE: seg_hex = 7'b0000110;
         default: seg_hex = 7'b0001110;
      endcase
   endfunction

   logic [DW-1:0] r_div;
   logic [9:0]    r_hc, r_vc;
   logic          w_pix_en, w_hwrap;

   assign w_pix_en = r_div == DW'(CLK_DIV - 1);
   assign w_hwrap  = r_hc == 10'd799;

   always_ff @(posedge ClkPort)
      if (BtnC) begin
         r_div <= '0;
         r_hc  <= '0;
         r_vc  <= '0;
      end else begin
         r_div <= w_pix_en ? '0 : r_div + 1'b1;
         if (w_pix_en) begin
            r_hc <= w_hwrap ? '0 : r_hc + 1'b1;
            if (w_hwrap) r_vc <= (r_vc == 10'd524) ? '0 : r_vc + 1'b1;
         end
      end

   logic [4:0]  r_px, r_py, w_tx, w_ty;
   logic [15:0] r_moves;
   logic        r_won, w_go;
   logic [9:0]  w_col, w_row;
   logic [31:0] w_vrow, w_trow;
   logic        w_vis, w_in_maze, w_wall;
   logic [11:0] w_rgb;

   assign w_col     = r_hc / 10'(CELL_PX);
   assign w_row     = r_vc / 10'(CELL_PX);
   assign w_vis     = r_hc < 10'd640 && r_vc < 10'd480;
   assign w_in_maze = w_col < 10'd30 && w_row < 10'd20;
   assign w_vrow    = {2'b00, map_row(w_row)};
   assign w_wall    = w_in_maze && w_vrow[w_col[4:0]];
   assign w_rgb     = (!w_vis || !w_in_maze)                      ? 12'h000 :
                      (w_col[4:0] == r_px && w_row[4:0] == r_py)  ? 12'hF00 :
                      (w_col == 10'd28 && w_row == 10'd18)        ? 12'h0F0 :
                      w_wall                                      ? 12'hFFF : 12'h002;

   logic        r_hs, r_vs;
   logic [11:0] r_rgb;

   always_ff @(posedge ClkPort)
      if (BtnC) begin
         r_hs  <= 1'b1;
         r_vs  <= 1'b1;
         r_rgb <= '0;
      end else begin
         r_hs  <= !(r_hc >= 10'd656 && r_hc < 10'd752);
         r_vs  <= !(r_vc >= 10'd490 && r_vc < 10'd492);
         r_rgb <= w_rgb;
      end

   logic [3:0]    w_btn, r_s1, r_s2, r_db, r_prev, w_pulse;
   logic [CW-1:0] r_cnt [4];

   assign w_btn   = {bus.BtnR, bus.BtnL, bus.BtnD, bus.BtnU};
   assign w_pulse = r_db & ~r_prev;

   always_ff @(posedge ClkPort)
      if (BtnC) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_db   <= '0;
         r_prev <= '0;
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      end else begin
         r_s1   <= w_btn;
         r_s2   <= r_s1;
         r_prev <= r_db;
         for (int i = 0; i < 4; i++)
            if (r_s2[i] == r_db[i]) r_cnt[i] <= '0;
            else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
               r_cnt[i] <= '0;
               r_db[i]  <= r_s2[i];
            end else r_cnt[i] <= r_cnt[i] + 1'b1;
      end

   // Pulse bits are U,D,L,R from bit 0 upward; a lower bit wins.
   assign w_ty   = w_pulse[0] ? r_py - 5'd1 : w_pulse[1] ? r_py + 5'd1 : r_py;
   assign w_tx   = (w_pulse[1:0] != 2'b00) ? r_px :
                   w_pulse[2] ? r_px - 5'd1 : w_pulse[3] ? r_px + 5'd1 : r_px;
   assign w_trow = {2'b00, map_row({5'd0, w_ty})};
   assign w_go   = (w_pulse != 4'b0000) && !r_won && !w_trow[w_tx];

   always_ff @(posedge ClkPort)
      if (BtnC) begin
         r_px    <= 5'd1;
         r_py    <= 5'd1;
         r_moves <= '0;
         r_won   <= 1'b0;
      end else if (w_go) begin
         r_px    <= w_tx;
         r_py    <= w_ty;
         r_moves <= r_moves + 16'd1;
         r_won   <= w_tx == 5'd28 && w_ty == 5'd18;
      end

   logic [18:0] r_ref;
   logic [7:0]  r_an;
   logic [6:0]  r_seg;
   logic [1:0]  w_sel;
   logic [3:0]  w_nib;

   assign w_sel = r_ref[18:17];
   assign w_nib = r_moves[{w_sel, 2'b00} +: 4];

   always_ff @(posedge ClkPort)
      if (BtnC) begin
         r_ref <= '0;
         r_an  <= 8'hFF;
         r_seg <= 7'h7F;
      end else begin
         r_ref <= r_ref + 1'b1;
         r_an  <= ~(8'd1 << w_sel);
         r_seg <= seg_hex(w_nib);
      end

   assign bus.hSync = r_hs;
   assign bus.vSync = r_vs;
   assign {bus.vgaR, bus.vgaG, bus.vgaB} = r_rgb;
   assign {bus.An7, bus.An6, bus.An5, bus.An4, bus.An3, bus.An2, bus.An1, bus.An0} = r_an;
   assign {bus.Cg, bus.Cf, bus.Ce, bus.Cd, bus.Cc, bus.Cb, bus.Ca} = r_seg;
   assign bus.Dp = 1'b1;
   assign x_coord = r_hc;
   assign y_coord = r_vc;
   assign map_data_out_debug = w_wall;
endmodule

// File: tb/tb_vga_maze_top.sv
// tb_vga_maze_top: directed checks of VGA timing, maze rendering, movement and the move counter.
module tb_vga_maze_top;
   logic       clk = 1'b0;
   logic       BtnC;
   logic [9:0] x_coord, y_coord;
   logic       map_dbg;
   int         n_chk = 0;
   int         n_fail = 0;

   vga_maze_top_if bus ();

   vga_maze_top #(.DEBOUNCE_CYCLES(4)) dut (
      .ClkPort(clk), .BtnC(BtnC), .bus(bus),
      .x_coord(x_coord), .y_coord(y_coord), .map_data_out_debug(map_dbg)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] rgb();
      return {bus.vgaR, bus.vgaG, bus.vgaB};
   endfunction

   function automatic logic [7:0] anodes();
      return {bus.An7, bus.An6, bus.An5, bus.An4, bus.An3, bus.An2, bus.An1, bus.An0};
   endfunction

   function automatic logic [6:0] segs();
      return {bus.Cg, bus.Cf, bus.Ce, bus.Cd, bus.Cc, bus.Cb, bus.Ca};
   endfunction

   task automatic wait_px(input int x, input int y, input int lim);
      int n = 0;
      while (!(x_coord == 10'(x) && y_coord == 10'(y)) && n < lim) begin
         @(negedge clk);
         n++;
      end
      n_chk++;
      if (x_coord != 10'(x) || y_coord != 10'(y)) begin
         n_fail++;
         $display("FAIL wait_px: at (%0d,%0d), required (%0d,%0d)", x_coord, y_coord, x, y);
      end
   endtask

   task automatic press(input logic [3:0] m, input int hold);
      @(negedge clk);
      {bus.BtnR, bus.BtnL, bus.BtnD, bus.BtnU} = m;
      repeat (hold) @(negedge clk);
      {bus.BtnR, bus.BtnL, bus.BtnD, bus.BtnU} = 4'b0000;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset();
      BtnC = 1'b1;
      {bus.BtnR, bus.BtnL, bus.BtnD, bus.BtnU} = 4'b0000;
      repeat (6) @(negedge clk);
      n_chk++; if ({bus.hSync, bus.vSync} !== 2'b11) begin n_fail++; $display("FAIL reset_sync: got %b, required 11", {bus.hSync, bus.vSync}); end
      n_chk++; if (rgb() !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h, required 000", rgb()); end
      n_chk++; if (anodes() !== 8'hFF) begin n_fail++; $display("FAIL reset_an: got %h, required ff", anodes()); end
      n_chk++; if (segs() !== 7'h7F) begin n_fail++; $display("FAIL reset_seg: got %b, required 1111111", segs()); end
      n_chk++; if (bus.Dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b, required 1", bus.Dp); end
      n_chk++; if ({x_coord, y_coord} !== 20'd0) begin n_fail++; $display("FAIL reset_xy: got (%0d,%0d), required (0,0)", x_coord, y_coord); end
      n_chk++; if ({dut.r_px, dut.r_py, dut.r_moves} !== {5'd1, 5'd1, 16'd0}) begin n_fail++; $display("FAIL reset_player: got (%0d,%0d) n=%0d, required (1,1) n=0", dut.r_px, dut.r_py, dut.r_moves); end
      BtnC = 1'b0;
      @(negedge clk);
      n_chk++; if (rgb() !== 12'hFFF) begin n_fail++; $display("FAIL px0_rgb: got %h, required fff", rgb()); end
      n_chk++; if (map_dbg !== 1'b1) begin n_fail++; $display("FAIL px0_map: got %b, required 1", map_dbg); end
      repeat (2) @(negedge clk);
      n_chk++; if (x_coord !== 10'd0) begin n_fail++; $display("FAIL x_hold: got %0d, required 0", x_coord); end
      @(negedge clk);
      n_chk++; if (x_coord !== 10'd1) begin n_fail++; $display("FAIL x_step1: got %0d, required 1", x_coord); end
      repeat (4) @(negedge clk);
      n_chk++; if (x_coord !== 10'd2) begin n_fail++; $display("FAIL x_step2: got %0d, required 2", x_coord); end
   endtask

   task automatic test_line();
      int low = 0, first = -1, bad = 0, n = 0;
      wait_px(600, 0, 4000);
      @(negedge clk);
      n_chk++; if (rgb() !== 12'h000) begin n_fail++; $display("FAIL px600_rgb: got %h, required 000", rgb()); end
      n_chk++; if (map_dbg !== 1'b0) begin n_fail++; $display("FAIL px600_map: got %b, required 0", map_dbg); end
      while (x_coord != 10'd799 && n < 2000) begin
         if (!bus.hSync) begin
            low++;
            if (first < 0) first = int'(x_coord);
         end
         if (x_coord >= 10'd641 && rgb() != 12'h000) bad++;
         @(negedge clk);
         n++;
      end
      n_chk++; if (low != 384) begin n_fail++; $display("FAIL hsync_len: got %0d cycles, required 384", low); end
      n_chk++; if (first != 656) begin n_fail++; $display("FAIL hsync_start: got x=%0d, required 656", first); end
      n_chk++; if (bad != 0) begin n_fail++; $display("FAIL blank_rgb: got %0d nonzero samples, required 0", bad); end
      n_chk++; if (bus.vSync !== 1'b1) begin n_fail++; $display("FAIL vsync_line0: got %b, required 1", bus.vSync); end
      n = 0;
      while (x_coord != 10'd0 && n < 10) begin @(negedge clk); n++; end
      n_chk++; if ({x_coord, y_coord} !== {10'd0, 10'd1}) begin n_fail++; $display("FAIL hwrap: got (%0d,%0d), required (0,1)", x_coord, y_coord); end
   endtask

   task automatic test_render();
      wait_px(24, 16, 60000);
      @(negedge clk);
      n_chk++; if (rgb() !== 12'hF00) begin n_fail++; $display("FAIL player_rgb: got %h, required f00", rgb()); end
      n_chk++; if (map_dbg !== 1'b0) begin n_fail++; $display("FAIL player_map: got %b, required 0", map_dbg); end
      wait_px(40, 16, 200);
      @(negedge clk);
      n_chk++; if (rgb() !== 12'h002) begin n_fail++; $display("FAIL open_rgb: got %h, required 002", rgb()); end
      wait_px(56, 16, 200);
      @(negedge clk);
      n_chk++; if (rgb() !== 12'hFFF) begin n_fail++; $display("FAIL wall_rgb: got %h, required fff", rgb()); end
      n_chk++; if (map_dbg !== 1'b1) begin n_fail++; $display("FAIL wall_map: got %b, required 1", map_dbg); end
      wait_px(488, 16, 2000);
      @(negedge clk);
      n_chk++; if (rgb() !== 12'h000) begin n_fail++; $display("FAIL edge_rgb: got %h, required 000", rgb()); end
      n_chk++; if (map_dbg !== 1'b0) begin n_fail++; $display("FAIL edge_map: got %b, required 0", map_dbg); end
   endtask

   task automatic test_wall();
      n_chk++; if ({anodes(), segs()} !== {8'hFE, 7'b1000000}) begin n_fail++; $display("FAIL seg_zero: got an=%h seg=%b, required fe 1000000", anodes(), segs()); end
      press(4'b0001, 12);
      n_chk++; if ({dut.r_px, dut.r_py, dut.r_moves} !== {5'd1, 5'd1, 16'd0}) begin n_fail++; $display("FAIL wall_up: got (%0d,%0d) n=%0d, required (1,1) n=0", dut.r_px, dut.r_py, dut.r_moves); end
      press(4'b0100, 12);
      n_chk++; if ({dut.r_px, dut.r_py, dut.r_moves} !== {5'd1, 5'd1, 16'd0}) begin n_fail++; $display("FAIL wall_left: got (%0d,%0d) n=%0d, required (1,1) n=0", dut.r_px, dut.r_py, dut.r_moves); end
   endtask

   task automatic test_move();
      press(4'b1000, 12);
      n_chk++; if ({dut.r_px, dut.r_py, dut.r_moves} !== {5'd2, 5'd1, 16'd1}) begin n_fail++; $display("FAIL move_right: got (%0d,%0d) n=%0d, required (2,1) n=1", dut.r_px, dut.r_py, dut.r_moves); end
      n_chk++; if ({anodes(), segs()} !== {8'hFE, 7'b1111001}) begin n_fail++; $display("FAIL seg_one: got an=%h seg=%b, required fe 1111001", anodes(), segs()); end
      press(4'b0100, 12);
      n_chk++; if ({dut.r_px, dut.r_py, dut.r_moves} !== {5'd1, 5'd1, 16'd2}) begin n_fail++; $display("FAIL move_left: got (%0d,%0d) n=%0d, required (1,1) n=2", dut.r_px, dut.r_py, dut.r_moves); end
      n_chk++; if (segs() !== 7'b0100100) begin n_fail++; $display("FAIL seg_two: got %b, required 0100100", segs()); end
   endtask

   task automatic test_back_to_back();
      press(4'b1010, 12);
      n_chk++; if ({dut.r_px, dut.r_py, dut.r_moves} !== {5'd1, 5'd2, 16'd3}) begin n_fail++; $display("FAIL down_right: got (%0d,%0d) n=%0d, required (1,2) n=3", dut.r_px, dut.r_py, dut.r_moves); end
      press(4'b0010, 40);
      n_chk++; if ({dut.r_px, dut.r_py, dut.r_moves} !== {5'd1, 5'd3, 16'd4}) begin n_fail++; $display("FAIL hold_down: got (%0d,%0d) n=%0d, required (1,3) n=4", dut.r_px, dut.r_py, dut.r_moves); end
   endtask

   task automatic test_won();
      repeat (15) press(4'b0010, 12);
      n_chk++; if ({dut.r_px, dut.r_py, dut.r_moves} !== {5'd1, 5'd18, 16'd19}) begin n_fail++; $display("FAIL descend: got (%0d,%0d) n=%0d, required (1,18) n=19", dut.r_px, dut.r_py, dut.r_moves); end
      repeat (27) press(4'b1000, 12);
      n_chk++; if ({dut.r_px, dut.r_py, dut.r_moves, dut.r_won} !== {5'd28, 5'd18, 16'd46, 1'b1}) begin n_fail++; $display("FAIL goal: got (%0d,%0d) n=%0d won=%b, required (28,18) n=46 won=1", dut.r_px, dut.r_py, dut.r_moves, dut.r_won); end
      n_chk++; if (segs() !== 7'b0000110) begin n_fail++; $display("FAIL seg_e: got %b, required 0000110", segs()); end
      press(4'b0100, 12);
      press(4'b0001, 12);
      n_chk++; if ({dut.r_px, dut.r_py, dut.r_moves} !== {5'd28, 5'd18, 16'd46}) begin n_fail++; $display("FAIL frozen: got (%0d,%0d) n=%0d, required (28,18) n=46", dut.r_px, dut.r_py, dut.r_moves); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      BtnC = 1'b1;
      @(negedge clk);
      n_chk++; if ({x_coord, y_coord} !== 20'd0) begin n_fail++; $display("FAIL mid_xy: got (%0d,%0d), required (0,0)", x_coord, y_coord); end
      n_chk++; if ({dut.r_px, dut.r_py, dut.r_moves, dut.r_won} !== {5'd1, 5'd1, 16'd0, 1'b0}) begin n_fail++; $display("FAIL mid_player: got (%0d,%0d) n=%0d won=%b, required (1,1) n=0 won=0", dut.r_px, dut.r_py, dut.r_moves, dut.r_won); end
      BtnC = 1'b0;
   endtask

   initial begin
      test_reset();
      test_line();
      test_render();
      test_wall();
      test_move();
      test_back_to_back();
      test_won();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
